// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - positive-edge D flip-flop with asynchronous active-high reset
//
// Ports:
//   clk : clock; each rising edge loads d into q
//   rst : asynchronous active-high reset; forces q to RESET_VALUE
//   d   : data input, WIDTH bits
//   q   : registered data output, WIDTH bits
module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // rst is in the sensitivity list, so q reaches RESET_VALUE without a clock edge.
  // Any clock edge that arrives while rst is high still takes the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - scoreboard testbench for d_flip_flop at WIDTH=1 and WIDTH=8
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp1_q[$];
  logic [7:0] exp8_q[$];

  always #5 clk = ~clk;

  d_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .q(q1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .d(d8), .q(q8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, record what each flop must show after the
  // next rising edge, then compare once that edge has passed.
  task automatic cycle(input string tag, input logic dv1, input logic [7:0] dv8);
    logic [7:0] e1;
    logic [7:0] e8;
    d1 = dv1;
    d8 = dv8;
    exp1_q.push_back({7'b0, dv1});
    exp8_q.push_back(dv8);
    @(posedge clk);
    @(negedge clk);
    if (exp1_q.size() == 0 || exp8_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e1 = exp1_q.pop_front();
      e8 = exp8_q.pop_front();
      check({tag, "_q1"}, {7'b0, q1}, e1);
      check({tag, "_q8"}, q8, e8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic       basic_d [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] e1;
  logic [7:0] e8;

  initial begin
    // Reset state
    rst = 1'b1;
    d1  = 1'b0;
    d8  = 8'h00;
    #2;
    check("reset_q1", {7'b0, q1}, 8'h00);
    check("reset_q8", q8, 8'hA5);
    #1;
    rst = 1'b0;

    // Basic capture: d held for each cycle, q follows one edge later
    for (int i = 0; i < 9; i++) begin
      cycle($sformatf("basic%0d", i), basic_d[i], {4'h0, 3'b0, basic_d[i]});
    end

    // d glitches between edges must not reach q
    cycle("pre_glitch", 1'b0, 8'h11);
    d1 = 1'b1;
    d8 = 8'h22;
    exp1_q.push_back(8'h01);
    exp8_q.push_back(8'h22);
    @(posedge clk);
    #1 d1 = 1'b0; d8 = 8'hFF;
    #1 check("glitch_hold_q1", {7'b0, q1}, 8'h01);
    check("glitch_hold_q8", q8, 8'h22);
    #1 d1 = 1'b1; d8 = 8'h22;
    @(negedge clk);
    e1 = exp1_q.pop_front();
    e8 = exp8_q.pop_front();
    check("glitch_q1", {7'b0, q1}, e1);
    check("glitch_q8", q8, e8);
    // Falling edge with d changed: q must not move
    d1 = 1'b0;
    #1 check("negedge_hold_q1", {7'b0, q1}, 8'h01);

    // Asynchronous reset asserted between edges while q=1
    #2 rst = 1'b1;
    #1 check("async_rst_q1", {7'b0, q1}, 8'h00);
    check("async_rst_q8", q8, 8'hA5);
    d1 = 1'b1;
    d8 = 8'h3C;
    repeat (2) @(posedge clk);
    #1 check("rst_hold_q1", {7'b0, q1}, 8'h00);
    check("rst_hold_q8", q8, 8'hA5);

    // Release between edges: q stays at reset value until the next edge
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("release_hold_q1", {7'b0, q1}, 8'h00);
    check("release_hold_q8", q8, 8'hA5);
    @(posedge clk);
    #1 check("release_cap_q1", {7'b0, q1}, 8'h01);
    check("release_cap_q8", q8, 8'h3C);
    @(negedge clk);

    // Back-to-back pseudo-random data
    for (int i = 0; i < 100; i++) begin
      cycle($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    check("sb_drained", 8'(exp1_q.size() + exp8_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Positive-edge-triggered D-type storage register.
- Has an asynchronous active-high reset.
- Basic sequential primitive used by higher-level datapath and control blocks to delay a signal by one clock cycle.
- Width is parameterised; the default is a single-bit flop.

Parameters:
- WIDTH, 1, bit width of d and q.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q while rst is asserted.

Ports:
- clk  input  1  clock; rising edge samples d.
- rst  input  1  asynchronous active-high reset.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data output.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset:
  - Whenever rst goes high, q takes RESET_VALUE immediately, with no clock edge required.
  - q holds RESET_VALUE for as long as rst stays high. Clock edges are ignored during reset.
- Normal operation (rst low):
  - On each rising edge of clk, q <= d.
  - Latency is one cycle: a value on d just before edge N appears on q just after edge N.
- Between rising edges, q holds its value. Changes on d have no effect on q. Falling edges of clk have no effect.
- Reset deassertion:
  - The first rising edge after rst falls captures d.
  - If rst falls coincident with a rising edge, q stays at RESET_VALUE for that edge and the next edge captures d.
- Reset mid-operation: q is forced to RESET_VALUE asynchronously, whatever value was stored.
- Power-up:
  - Before the first reset or first clock edge, q is unspecified.
  - Users needing a defined value must assert rst or apply a clock edge.
- Setup and hold are not modelled. d changing exactly at a rising edge is a usage error for synthesis. In simulation, q takes the value of d present immediately before the edge.
- No enable, no synchronous clear, no combinational path from d to q.
- Width: every bit of d and q is treated independently and identically. No arithmetic is performed.

Decomposition:
- No shared package required; there are no typedefs or constants beyond the two parameters.
- No sub-module. The block is a single always_ff, sensitive to posedge clk and posedge rst.
- Multi-bit registers and pipelines are built by instantiating this block with WIDTH > 1 or by chaining instances.

Test Plan:
- Basic capture, WIDTH=1, clk period 10 ns starting low, rst=0:
  - Stimulus: d=0 at t=0, 1 at 10, 0 at 20, 1 at 30, 0 at 50, 1 at 70.
  - Required q after edges at t=5,15,25,35,45,55,65,75,85: 0,1,0,1,1,0,0,1,1.
- Mid-cycle d glitch:
  - Stimulus: toggle d 1->0->1 between t=16 and t=24.
  - Required: q remains at its t=15 value until the t=25 edge, then follows d=1.
- Asynchronous reset:
  - Stimulus: q=1, assert rst at t=38, between edges.
  - Required: q=0 at t=38, before the t=45 edge.
  - Required: q stays 0 across edges while rst=1, even with d=1.
- Reset release:
  - Stimulus: deassert rst at t=52 with d=1.
  - Required: q stays 0 until the t=55 edge, then q=1.
- Parameterised width:
  - Configuration: WIDTH=8, RESET_VALUE=8'hA5.
  - Stimulus: assert rst, then apply d=8'h3C.
  - Required: q=8'hA5 during reset, and q=8'h3C after the first rising edge following release.
- Back-to-back pattern:
  - Stimulus: drive d with a pseudo-random sequence for 100 cycles.
  - Required: q at each edge equals d sampled at that edge, i.e. d delayed by one cycle, with zero mismatches.
